// File: rtl/round_arb.sv
// round_arb -- round-robin arbiter in front of a shared convergent rounder.
//
// Accepts at most one word per cycle from N_REQ requesters, registers it onto
// the rounder input, carries the requester index alongside the rounder for LAT
// cycles and routes each rounded result back to its requester one cycle after
// the rounder produces it. A sticky flag reports any cycle where the rounder's
// output valid disagrees with the tracked tag.
//
// Parameters: N_REQ (2..8), IN_W, OUT_W (<= IN_W), LAT (>= 1) rounder latency.
// Ports:
//   clk          rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_init       synchronous flush
//   i_req_vld    per-requester valid
//   i_req_data   requester k word at [k*IN_W +: IN_W]
//   o_req_rdy    one-hot combinational grant
//   o_rnd_init   registered i_init, to the rounder
//   o_rnd_vld    rounder input valid
//   o_rnd_data   rounder input word
//   i_rnd_vld    rounder output valid
//   i_rnd_data   rounder output word
//   o_rsp_vld    one-hot response valid
//   o_rsp_data   rounded result
//   o_err        sticky tag/valid mismatch flag
//
// Build option: define ROUND_ARB_PRIO0_EN to give requester 0 strict priority;
// requesters 1..N_REQ-1 then rotate among themselves and a grant to 0 leaves
// the rotation pointer untouched.

module round_arb #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int LAT   = 1
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_init,
    input  logic [N_REQ-1:0]        i_req_vld,
    input  logic [N_REQ*IN_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]        o_req_rdy,
    output logic                    o_rnd_init,
    output logic                    o_rnd_vld,
    output logic [IN_W-1:0]         o_rnd_data,
    input  logic                    i_rnd_vld,
    input  logic [OUT_W-1:0]        i_rnd_data,
    output logic [N_REQ-1:0]        o_rsp_vld,
    output logic [OUT_W-1:0]        o_rsp_data,
    output logic                    o_err
);

`ifdef ROUND_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IGN_W = $clog2(LAT + 2);
    localparam int TAG_W = LAT * IDX_W;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             rnd_vld_q, rnd_vld_d;
    logic [IN_W-1:0]  rnd_data_q, rnd_data_d;
    logic [IDX_W-1:0] rnd_idx_q, rnd_idx_d;
    logic             rnd_init_q, rnd_init_d;
    logic [LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [TAG_W-1:0] tag_idx_q, tag_idx_d;
    logic [IGN_W-1:0] ign_q, ign_d;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic             err_q, err_d;

    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             tag_out_vld;
    logic [IDX_W-1:0] tag_out_idx;
    logic             ign_active;
    logic             hit;
    logic             mism;

    // Grant: first valid requester at or above ptr, wrapping. With the
    // priority option, requester 0 wins outright and is skipped by the scan.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        o_req_rdy = '0;
        if (i_rst_n && !i_init) begin
            if (PRIO0 && i_req_vld[0]) begin
                gnt_vld = 1'b1;
                gnt_idx = '0;
            end
            for (int unsigned off = 0; off < N_REQ; off++) begin
                cand = (32'(ptr_q) + off) % N_REQ;
                if (!gnt_vld && i_req_vld[cand] && !(PRIO0 && cand == 0)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDX_W'(cand);
                end
            end
            if (gnt_vld) begin
                o_req_rdy[gnt_idx] = 1'b1;
            end
        end
    end

    // Tag pipe is a packed shift register; the oldest entry sits in the top
    // slot and lines up with the rounder's output.
    always_comb begin
        ptr_d       = ptr_q;
        rnd_vld_d   = rnd_vld_q;
        rnd_data_d  = rnd_data_q;
        rnd_idx_d   = rnd_idx_q;
        rnd_init_d  = rnd_init_q;
        tag_vld_d   = tag_vld_q;
        tag_idx_d   = tag_idx_q;
        ign_d       = ign_q;
        rsp_vld_d   = rsp_vld_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;

        tag_out_vld = tag_vld_q[LAT-1];
        tag_out_idx = tag_idx_q[TAG_W-1 -: IDX_W];
        ign_active  = (ign_q != '0);
        hit         = !ign_active && tag_out_vld && i_rnd_vld;
        mism        = !ign_active && (tag_out_vld != i_rnd_vld);

        if (i_init) begin
            ptr_d      = '0;
            rnd_vld_d  = 1'b0;
            rnd_init_d = 1'b1;
            tag_vld_d  = '0;
            tag_idx_d  = '0;
            ign_d      = IGN_W'(LAT + 1);
            rsp_vld_d  = '0;
            err_d      = 1'b0;
        end else begin
            rnd_init_d = 1'b0;
            rnd_vld_d  = gnt_vld;
            if (gnt_vld) begin
                rnd_data_d = i_req_data[32'(gnt_idx)*IN_W +: IN_W];
                rnd_idx_d  = gnt_idx;
                if (!(PRIO0 && gnt_idx == '0)) begin
                    ptr_d = IDX_W'((32'(gnt_idx) + 1) % N_REQ);
                end
            end

            tag_vld_d = (tag_vld_q << 1) | LAT'(rnd_vld_q);
            tag_idx_d = (tag_idx_q << IDX_W) | TAG_W'(rnd_idx_q);

            // Results still draining from before a flush must not be routed
            // or counted as mismatches.
            if (ign_active) begin
                ign_d = ign_q - IGN_W'(1);
            end

            rsp_vld_d = '0;
            if (hit) begin
                rsp_vld_d[tag_out_idx] = 1'b1;
                rsp_data_d             = i_rnd_data;
            end

            err_d = err_q | mism;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            rnd_vld_q  <= 1'b0;
            rnd_data_q <= '0;
            rnd_idx_q  <= '0;
            rnd_init_q <= 1'b0;
            tag_vld_q  <= '0;
            tag_idx_q  <= '0;
            ign_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rnd_vld_q  <= rnd_vld_d;
            rnd_data_q <= rnd_data_d;
            rnd_idx_q  <= rnd_idx_d;
            rnd_init_q <= rnd_init_d;
            tag_vld_q  <= tag_vld_d;
            tag_idx_q  <= tag_idx_d;
            ign_q      <= ign_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign o_rnd_init = rnd_init_q;
    assign o_rnd_vld  = rnd_vld_q;
    assign o_rnd_data = rnd_data_q;
    assign o_rsp_vld  = rsp_vld_q;
    assign o_rsp_data = rsp_data_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_round_arb.sv
// Testbench for round_arb: stub rounder plus a queue-based reference model.

module tb_round_arb;

    localparam int N   = 4;
    localparam int IW  = 24;
    localparam int OW  = 16;
    localparam int LAT = 1;
    localparam int SH  = IW - OW;

`ifdef ROUND_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              init;
    logic [N-1:0]      req_vld;
    logic [N*IW-1:0]   req_data;
    logic [N-1:0]      o_req_rdy;
    logic              o_rnd_init;
    logic              o_rnd_vld;
    logic [IW-1:0]     o_rnd_data;
    logic              rnd_vld_in;
    logic [OW-1:0]     rnd_data_in;
    logic [N-1:0]      o_rsp_vld;
    logic [OW-1:0]     o_rsp_data;
    logic              o_err;

    logic              drop_now;
    logic              spur_now;

    int tests = 0;
    int fails = 0;

    round_arb #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .LAT(LAT)) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_init     (init),
        .i_req_vld  (req_vld),
        .i_req_data (req_data),
        .o_req_rdy  (o_req_rdy),
        .o_rnd_init (o_rnd_init),
        .o_rnd_vld  (o_rnd_vld),
        .o_rnd_data (o_rnd_data),
        .i_rnd_vld  (rnd_vld_in),
        .i_rnd_data (rnd_data_in),
        .o_rsp_vld  (o_rsp_vld),
        .o_rsp_data (o_rsp_data),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Convergent (round-half-even) narrowing by SH bits.
    function automatic logic [OW-1:0] rnd(input logic [IW-1:0] d);
        logic [IW-1:0] q;
        logic [SH-1:0] f;
        logic [SH-1:0] half;
        q    = $signed(d) >>> SH;
        f    = d[SH-1:0];
        half = SH'(1) << (SH - 1);
        if (f > half || (f == half && q[0])) q = q + IW'(1);
        return q[OW-1:0];
    endfunction

    // Stub rounder with fault hooks: drop_now suppresses one result,
    // spur_now injects a result nobody asked for.
    logic [LAT-1:0] sv;
    logic [OW-1:0]  sd [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int i = 0; i < LAT; i++) sd[i] <= '0;
        end else begin
            sv    <= (sv << 1) | LAT'((o_rnd_vld && !drop_now) || spur_now);
            sd[0] <= spur_now ? 16'hBEEF : rnd(o_rnd_data);
            for (int i = 1; i < LAT; i++) sd[i] <= sd[i-1];
        end
    end
    assign rnd_vld_in  = sv[LAT-1];
    assign rnd_data_in = sd[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            idx;
        logic [IW-1:0] d;
        int            due;
    } ent_t;

    ent_t          q[$];
    int            mptr  = 0;
    int            m_ign = 0;
    int            cyc   = 0;
    bit            m_err = 1'b0;
    logic [N-1:0]  e_rsp_vld  = '0;
    logic [OW-1:0] e_rsp_data = '0;
    logic          e_rnd_vld  = 1'b0;
    logic [IW-1:0] e_rnd_data = '0;
    logic          e_rnd_init = 1'b0;

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        if (PRIO0 && v[0]) return 0;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (p + off) % N;
            if (!(PRIO0 && k == 0) && v[k]) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] eg;
        logic         tagv;
        ent_t         e;
        if (!rst_n) begin
            check("rst_rdy",      64'(o_req_rdy),  64'(0));
            check("rst_rnd_vld",  64'(o_rnd_vld),  64'(0));
            check("rst_rnd_data", 64'(o_rnd_data), 64'(0));
            check("rst_rnd_init", 64'(o_rnd_init), 64'(0));
            check("rst_rsp_vld",  64'(o_rsp_vld),  64'(0));
            check("rst_rsp_data", 64'(o_rsp_data), 64'(0));
            check("rst_err",      64'(o_err),      64'(0));
            q.delete();
            mptr = 0; m_ign = 0; m_err = 1'b0;
            e_rsp_vld = '0; e_rsp_data = '0;
            e_rnd_vld = 1'b0; e_rnd_data = '0; e_rnd_init = 1'b0;
        end else begin
            g  = init ? -1 : model_grant(req_vld, mptr);
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            check("grant",    64'(o_req_rdy),  64'(eg));
            check("rnd_vld",  64'(o_rnd_vld),  64'(e_rnd_vld));
            check("rnd_data", 64'(o_rnd_data), 64'(e_rnd_data));
            check("rnd_init", 64'(o_rnd_init), 64'(e_rnd_init));
            check("rsp_vld",  64'(o_rsp_vld),  64'(e_rsp_vld));
            check("rsp_data", 64'(o_rsp_data), 64'(e_rsp_data));
            check("err",      64'(o_err),      64'(m_err));

            if (init) begin
                q.delete();
                mptr = 0; m_ign = LAT + 1; m_err = 1'b0;
                e_rsp_vld = '0; e_rnd_vld = 1'b0; e_rnd_init = 1'b1;
            end else begin
                e_rnd_init = 1'b0;
                tagv = (q.size() > 0) && (q[0].due == cyc);
                if (tagv) e = q.pop_front();
                e_rsp_vld = '0;
                if (m_ign > 0) begin
                    m_ign--;
                end else begin
                    if (tagv != rnd_vld_in) m_err = 1'b1;
                    if (tagv && rnd_vld_in) begin
                        e_rsp_vld[e.idx] = 1'b1;
                        e_rsp_data       = rnd(e.d);
                    end
                end
                if (g >= 0) begin
                    e.idx = g;
                    e.d   = req_data[g*IW +: IW];
                    e.due = cyc + 1 + LAT;
                    q.push_back(e);
                    e_rnd_vld  = 1'b1;
                    e_rnd_data = e.d;
                    if (!(PRIO0 && g == 0)) mptr = (g + 1) % N;
                end else begin
                    e_rnd_vld = 1'b0;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) req_data[k*IW +: IW] = IW'($urandom);
    endtask

    task automatic flush();
        init = 1'b1;
        tick();
        init = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; init = 1'b0; req_vld = '0; req_data = '0;
        drop_now = 1'b0; spur_now = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single requester, pointer at 0 after reset
        req_vld = 4'b0100;
        req_data[2*IW +: IW] = 24'h000100;
        @(negedge clk); check("single_rdy", 64'(o_req_rdy), 64'h4);
        tick(); req_vld = '0;
        @(negedge clk);
        check("single_rnd_vld",  64'(o_rnd_vld),  64'h1);
        check("single_rnd_data", 64'(o_rnd_data), 64'h100);
        tick(); tick();
        @(negedge clk);
        check("single_rsp_vld",  64'(o_rsp_vld),  64'h4);
        check("single_rsp_data", 64'(o_rsp_data), 64'h1);
        tick();
        flush();

        // All valid: strict rotation
        req_vld = '1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            @(negedge clk); check("rr_grant", 64'(o_req_rdy), 64'(1) << (i % N));
            tick();
        end
        req_vld = '0;
        repeat (4) tick();
        @(negedge clk); check("rr_no_err", 64'(o_err), 64'h0);
        tick();

        // Flush with two words in flight
        req_vld = '1;
        rand_data(); tick();
        rand_data(); tick();
        init = 1'b1;
        @(negedge clk); check("flush_no_grant", 64'(o_req_rdy), 64'h0);
        tick(); init = 1'b0;
        @(negedge clk);
        check("flush_rnd_init_on", 64'(o_rnd_init), 64'h1);
        check("flush_rsp_quiet0",  64'(o_rsp_vld),  64'h0);
        check("flush_ptr0",        64'(o_req_rdy),  64'h1);
        tick(); req_vld = '0;
        @(negedge clk);
        check("flush_rnd_init_off", 64'(o_rnd_init), 64'h0);
        check("flush_rsp_quiet1",   64'(o_rsp_vld),  64'h0);
        repeat (5) tick();
        @(negedge clk); check("flush_no_err", 64'(o_err), 64'h0);
        tick();

        // Dropped rounder valid
        req_vld = 4'b0010; rand_data();
        tick(); req_vld = '0; drop_now = 1'b1;
        tick(); drop_now = 1'b0;
        tick();
        @(negedge clk); check("drop_err", 64'(o_err), 64'h1);
        repeat (3) tick();
        @(negedge clk); check("drop_err_held", 64'(o_err), 64'h1);
        tick();
        flush();
        @(negedge clk); check("init_clears_err", 64'(o_err), 64'h0);

        // Spurious rounder valid with no tags
        spur_now = 1'b1;
        tick(); spur_now = 1'b0;
        tick();
        @(negedge clk); check("spur_err", 64'(o_err), 64'h1);
        tick();
        flush();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            req_vld = N'($urandom);
            rand_data();
            init = ($urandom_range(0, 39) == 0);
            tick();
        end
        init = 1'b0; req_vld = '0;
        repeat (6) tick();

        // Asynchronous reset between edges during traffic
        req_vld = '1;
        repeat (5) begin rand_data(); tick(); end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_rdy",      64'(o_req_rdy),  64'h0);
        check("arst_rnd_vld",  64'(o_rnd_vld),  64'h0);
        check("arst_rnd_data", 64'(o_rnd_data), 64'h0);
        check("arst_rsp_vld",  64'(o_rsp_vld),  64'h0);
        check("arst_rsp_data", 64'(o_rsp_data), 64'h0);
        check("arst_err",      64'(o_err),      64'h0);
        tick(); tick();
        req_vld = 4'b1010; rst_n = 1'b1;
        @(negedge clk); check("post_reset_grant", 64'(o_req_rdy), 64'h2);
        tick(); req_vld = '0;
        repeat (6) tick();

`ifdef ROUND_ARB_PRIO0_EN
        flush();
        req_vld = '1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            @(negedge clk); check("prio0_grant", 64'(o_req_rdy), 64'h1);
            tick();
        end
        req_vld = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            @(negedge clk); check("prio_rr_grant", 64'(o_req_rdy), 64'(1) << (i + 1));
            tick();
        end
        req_vld = '0;
        repeat (6) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
